bcd_countdown_timer: RTL and testbench
======================================

Name: bcd_countdown_timer

Overview:
- MM:SS egg-timer core. Holds the set time as four BCD digits, counts down once per second, and flags expiry.
- Digits feed the display scan/mux stage, which drives the BCD-to-segment decoder one digit at a time.
- Digit codes 0–9 are real digits. Code 4'hF is the "dash" glyph, used for the expiry blink.
- Buttons arrive already debounced as single-cycle pulses.

Parameters:
- TICK_DIV, 100_000_000: clock cycles per one-second tick. Must be even and ≥ 4.
- MAX_MIN, 59: highest settable minutes value (BCD 00..MAX_MIN).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- btn_start  in  1  pulse; meaning depends on state: start / pause / resume / acknowledge
- btn_clear  in  1  pulse; clear to 00:00 and return to IDLE
- btn_min_inc  in  1  pulse; increment minutes (IDLE only)
- btn_sec_inc  in  1  pulse; increment seconds (IDLE only)
- min_tens  out  4  BCD digit, or 4'hF
- min_ones  out  4  BCD digit, or 4'hF
- sec_tens  out  4  BCD digit, or 4'hF
- sec_ones  out  4  BCD digit, or 4'hF
- running  out  1  high in RUN
- alarm  out  1  high in DONE

Behaviour:
- Clock and reset: single clock domain (clk); reset is synchronous and active-high. All outputs are registered.
- Reset response:
  - state = IDLE; time and preset = 00:00; prescaler = 0; blink phase = 0.
  - All digit outputs 4'h0; running = 0; alarm = 0.
  - Reset asserted mid-RUN/PAUSE/DONE gives the same result on the next edge.
- Event priority each cycle: reset > btn_clear > btn_start > inc buttons. Both inc buttons in the same cycle: both applied.
- IDLE:
  - btn_sec_inc: seconds 00→59 in BCD, then wraps 59→00 with no carry into minutes.
  - btn_min_inc: minutes 00→MAX_MIN, then wraps to 00.
  - btn_clear: time = 00:00.
  - btn_start with time ≠ 00:00: preset ← time, prescaler ← 0, go to RUN.
  - btn_start at 00:00: ignored.
- RUN:
  - Prescaler counts 0..TICK_DIV-1. Tick = prescaler at TICK_DIV-1; prescaler then wraps to 0.
  - First decrement occurs exactly TICK_DIV cycles after entering RUN from IDLE.
  - Tick performs a BCD decrement:
    - sec_ones 0→9 borrows from sec_tens;
    - sec_tens 0→5 borrows from min_ones;
    - min_ones 0→9 borrows from min_tens.
  - A decrement that reaches 00:00 moves to DONE on the same edge. Outputs show 00:00, running = 0, alarm = 1, prescaler = 0, blink phase = 0.
  - btn_start: go to PAUSE; prescaler value is held. If a tick coincides with btn_start, the decrement is still applied.
  - btn_clear: go to IDLE with 00:00. A coincident tick is discarded.
  - Inc buttons: ignored.
- PAUSE:
  - Time and prescaler frozen.
  - btn_start: go to RUN, resuming from the held prescaler count. Total RUN cycles between decrements stay TICK_DIV.
  - btn_clear: go to IDLE with 00:00. Inc buttons: ignored.
- DONE:
  - alarm = 1.
  - Prescaler free-runs; blink phase toggles every TICK_DIV/2 cycles.
  - Phase 0: all four digits 4'h0. Phase 1: all four digits 4'hF.
  - btn_start: go to IDLE with time ← preset, alarm = 0.
  - btn_clear: go to IDLE with 00:00. Inc buttons: ignored.
- Digit outputs:
  - Never emit codes 4'hA–4'hE.
  - Never emit 4'hF outside DONE phase 1.
  - Seconds tens digit never exceeds 5.

Test Plan:
1. Reset: pulse reset during RUN → next edge all digits 0, running = 0, alarm = 0. btn_start then ignored (time 00:00).
2. Set and borrow (TICK_DIV = 4): 1×min_inc, 5×sec_inc → 01:05. Start → running = 1, 01:04 after 4 cycles, 01:00 after 20, 00:59 after 24.
3. Expiry and blink (TICK_DIV = 4): set 00:02, start.
   - Cycle 8: 00:00 with alarm = 1, running = 0.
   - Cycles 8–9: digits 0; cycles 10–11: digits F; cycles 12–13: digits 0.
   - btn_start → IDLE showing 00:02, alarm = 0.
4. Pause/resume (TICK_DIV = 4): set 00:10, start, pause 2 cycles after start, hold 20 cycles (digits stay 00:10). Resume → 00:09 exactly 2 cycles later.
5. Wrap: 60×sec_inc from 00 → 00. MAX_MIN+1 min_inc → 00. Same-cycle min_inc + sec_inc from 00:00 → 01:01.
6. Priority:
   - btn_clear + btn_start together in RUN → IDLE 00:00.
   - btn_start on a tick cycle in RUN → decrement applied and PAUSE entered.
   - btn_clear in DONE → IDLE 00:00, not the preset.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// MM:SS countdown timer core: BCD set/run/pause/expire with a blinking dash on expiry.
// Latency: every button pulse takes effect on the next clk edge; all outputs are registered.
// Backpressure: none; each single-cycle button pulse is acted on, or dropped, in the cycle it arrives.
module bcd_countdown_timer #(
  parameter int TICK_DIV = 100_000_000,
  parameter int MAX_MIN  = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_min_inc,
  input  logic       btn_sec_inc,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       alarm
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [15:0]   time_q, time_d;       // {min_tens, min_ones, sec_tens, sec_ones}
  logic [15:0]   preset_q, preset_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          blink_q, blink_d;
  logic [15:0]   digits_q, digits_d;
  logic          running_q, running_d;
  logic          alarm_q, alarm_d;
  logic          tick;
  logic [15:0]   dec_time;

  // One-second BCD decrement with borrow chain sec_ones -> sec_tens -> min_ones -> min_tens.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (so != 4'd0) so = so - 4'd1;
    else begin
      so = 4'd9;
      if (st != 4'd0) st = st - 4'd1;
      else begin
        st = 4'd5;
        if (mo != 4'd0) mo = mo - 4'd1;
        else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  // Seconds advance 00..59 and wrap to 00 without touching minutes.
  function automatic logic [7:0] sec_inc(input logic [7:0] s);
    logic [3:0] st, so;
    {st, so} = s;
    if (so == 4'd9) begin
      so = 4'd0;
      st = (st == 4'd5) ? 4'd0 : st + 4'd1;
    end else begin
      so = so + 4'd1;
    end
    return {st, so};
  endfunction

  // Minutes advance 00..MAX_MIN and wrap to 00.
  function automatic logic [7:0] min_inc(input logic [7:0] m);
    int v;
    v = 10 * int'(m[7:4]) + int'(m[3:0]);
    v = (v >= MAX_MIN) ? 0 : v + 1;
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  assign tick     = (presc_q == PRESC_MAX);
  assign dec_time = bcd_dec(time_q);

  // Next-state logic: clear outranks start, start outranks the increment buttons.
  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    preset_d = preset_q;
    presc_d  = presc_q;
    blink_d  = blink_q;
    case (state_q)
      S_IDLE: begin
        if (btn_clear) begin
          time_d = 16'h0000;
        end else if (btn_start) begin
          if (time_q != 16'h0000) begin
            preset_d = time_q;
            presc_d  = '0;
            state_d  = S_RUN;
          end
        end else begin
          if (btn_sec_inc) time_d[7:0]  = sec_inc(time_q[7:0]);
          if (btn_min_inc) time_d[15:8] = min_inc(time_q[15:8]);
        end
      end
      S_RUN: begin
        if (btn_clear) begin
          // A tick landing on the same edge is discarded.
          time_d  = 16'h0000;
          presc_d = '0;
          state_d = S_IDLE;
        end else begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            time_d = dec_time;
            if (dec_time == 16'h0000) begin
              // Expiry wins over a coincident pause request.
              state_d = S_DONE;
              presc_d = '0;
              blink_d = 1'b0;
            end else if (btn_start) begin
              state_d = S_PAUSE;
            end
          end else if (btn_start) begin
            state_d = S_PAUSE;
          end
        end
      end
      S_PAUSE: begin
        if (btn_clear) begin
          time_d  = 16'h0000;
          presc_d = '0;
          state_d = S_IDLE;
        end else if (btn_start) begin
          // Prescaler keeps its held count so RUN time between ticks stays TICK_DIV.
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (btn_clear) begin
          time_d  = 16'h0000;
          presc_d = '0;
          blink_d = 1'b0;
          state_d = S_IDLE;
        end else if (btn_start) begin
          time_d  = preset_q;
          presc_d = '0;
          blink_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick || presc_q == PRESC_HALF) blink_d = ~blink_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output values are derived from the next state so the registered outputs track state exactly.
  always_comb begin
    digits_d  = time_d;
    if (state_d == S_DONE) digits_d = blink_d ? 16'hFFFF : 16'h0000;
    running_d = (state_d == S_RUN);
    alarm_d   = (state_d == S_DONE);
  end

  // State, time, prescaler and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      time_q    <= 16'h0000;
      preset_q  <= 16'h0000;
      presc_q   <= '0;
      blink_q   <= 1'b0;
      digits_q  <= 16'h0000;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      preset_q  <= preset_d;
      presc_q   <= presc_d;
      blink_q   <= blink_d;
      digits_q  <= digits_d;
      running_q <= running_d;
      alarm_q   <= alarm_d;
    end
  end

  assign {min_tens, min_ones, sec_tens, sec_ones} = digits_q;
  assign running = running_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for the countdown timer, built with TICK_DIV = 4.
// Table of {pulse, cycles, expected display} records plus hand-written corner sequences.
// Outputs are sampled 1 time unit after each rising edge.
module tb_bcd_countdown_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       b_start = 1'b0, b_clear = 1'b0, b_min = 1'b0, b_sec = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, alarm;

  int nvec  = 0;
  int nfail = 0;

  bcd_countdown_timer #(.TICK_DIV(4), .MAX_MIN(59)) dut (
    .clk         (clk),
    .reset       (rst),
    .btn_start   (b_start),
    .btn_clear   (b_clear),
    .btn_min_inc (b_min),
    .btn_sec_inc (b_sec),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .running     (running),
    .alarm       (alarm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s, c, m, sc;  // button pulses applied on the first cycle
    int          n;            // total cycles before comparing
    logic [15:0] d;            // expected {min_tens, min_ones, sec_tens, sec_ones}
    logic        r, a;         // expected running, alarm
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic s, c, m, sc, input int n,
                     input logic [15:0] d, input logic r, a);
    vec_t v;
    v.s = s; v.c = c; v.m = m; v.sc = sc; v.n = n; v.d = d; v.r = r; v.a = a;
    tv.push_back(v);
  endtask

  task automatic step(input logic r, s, c, m, sc);
    rst = r; b_start = s; b_clear = c; b_min = m; b_sec = sc;
    @(posedge clk);
    #1;
    rst = 1'b0; b_start = 1'b0; b_clear = 1'b0; b_min = 1'b0; b_sec = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
  endtask

  task automatic check(input string name, input logic [15:0] d, input logic r, a);
    logic [15:0] got;
    got = {min_tens, min_ones, sec_tens, sec_ones};
    nvec++;
    if (got !== d || running !== r || alarm !== a) begin
      nfail++;
      $display("FAIL %s: got digits=%h running=%b alarm=%b, expected digits=%h running=%b alarm=%b",
               name, got, running, alarm, d, r, a);
    end
  endtask

  initial begin
    int e;

    // Set 01:05 and count through the borrows.
    add(0,0,1,0, 1, 16'h0100, 0,0);
    add(0,0,0,1, 1, 16'h0101, 0,0);
    add(0,0,0,1, 1, 16'h0102, 0,0);
    add(0,0,0,1, 1, 16'h0103, 0,0);
    add(0,0,0,1, 1, 16'h0104, 0,0);
    add(0,0,0,1, 1, 16'h0105, 0,0);
    add(1,0,0,0, 1, 16'h0105, 1,0);   // start
    add(0,0,0,0, 3, 16'h0105, 1,0);   // cycle 3
    add(0,0,0,0, 1, 16'h0104, 1,0);   // cycle 4
    add(0,0,0,0,16, 16'h0100, 1,0);   // cycle 20
    add(0,0,0,0, 3, 16'h0100, 1,0);   // cycle 23
    add(0,0,0,0, 1, 16'h0059, 1,0);   // cycle 24
    add(1,1,0,0, 1, 16'h0000, 0,0);   // clear beats start in RUN
    // Expiry and blink from 00:02.
    add(0,0,0,1, 1, 16'h0001, 0,0);
    add(0,0,0,1, 1, 16'h0002, 0,0);
    add(1,0,0,0, 1, 16'h0002, 1,0);
    add(0,0,0,0, 3, 16'h0002, 1,0);   // cycle 3
    add(0,0,0,0, 1, 16'h0001, 1,0);   // cycle 4
    add(0,0,0,0, 3, 16'h0001, 1,0);   // cycle 7
    add(0,0,0,0, 1, 16'h0000, 0,1);   // cycle 8
    add(0,0,0,0, 1, 16'h0000, 0,1);   // cycle 9
    add(0,0,0,0, 1, 16'hFFFF, 0,1);   // cycle 10
    add(0,0,0,0, 1, 16'hFFFF, 0,1);   // cycle 11
    add(0,0,0,0, 1, 16'h0000, 0,1);   // cycle 12
    add(0,0,0,0, 1, 16'h0000, 0,1);   // cycle 13
    add(0,0,0,0, 1, 16'hFFFF, 0,1);   // cycle 14
    add(1,0,0,0, 1, 16'h0002, 0,0);   // acknowledge restores preset
    add(1,0,0,0, 1, 16'h0002, 1,0);   // run again from preset
    add(0,0,0,0, 8, 16'h0000, 0,1);   // expired
    add(0,1,0,0, 1, 16'h0000, 0,0);   // clear in DONE gives 00:00
    add(1,0,0,0, 1, 16'h0000, 0,0);   // start at 00:00 ignored

    // Reset state.
    step(1, 0, 0, 0, 0);
    check("reset", 16'h0000, 0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      step(0, tv[i].s, tv[i].c, tv[i].m, tv[i].sc);
      idle(tv[i].n - 1);
      check($sformatf("vec%0d", i), tv[i].d, tv[i].r, tv[i].a);
    end

    // Seconds wrap 59 -> 00 without carry.
    for (int i = 1; i <= 60; i++) begin
      step(0, 0, 0, 0, 1);
      e = i % 60;
      check($sformatf("sec_wrap%0d", i), {8'h00, 4'(e / 10), 4'(e % 10)}, 0, 0);
    end
    // Minutes wrap MAX_MIN -> 00.
    for (int i = 1; i <= 60; i++) begin
      step(0, 0, 0, 1, 0);
      e = i % 60;
      check($sformatf("min_wrap%0d", i), {4'(e / 10), 4'(e % 10), 8'h00}, 0, 0);
    end
    step(0, 0, 0, 1, 1);
    check("both_inc", 16'h0101, 0, 0);
    step(0, 0, 1, 0, 0);
    check("idle_clear", 16'h0000, 0, 0);

    // Pause and resume from 00:10.
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);
    check("set_0010", 16'h0010, 0, 0);
    step(0, 1, 0, 0, 0);
    check("pr_start", 16'h0010, 1, 0);
    idle(1);
    step(0, 1, 0, 0, 0);
    check("pr_pause", 16'h0010, 0, 0);
    idle(10);
    check("pr_hold10", 16'h0010, 0, 0);
    idle(10);
    check("pr_hold20", 16'h0010, 0, 0);
    step(0, 1, 0, 0, 0);
    check("pr_resume", 16'h0010, 1, 0);
    idle(1);
    check("pr_resume1", 16'h0010, 1, 0);
    idle(1);
    check("pr_resume2", 16'h0009, 1, 0);

    // Pause pressed on a tick edge: the decrement still lands.
    idle(3);
    check("tick_pre", 16'h0009, 1, 0);
    step(0, 1, 0, 0, 0);
    check("tick_pause", 16'h0008, 0, 0);
    idle(5);
    check("tick_hold", 16'h0008, 0, 0);

    // Reset while running.
    step(0, 1, 0, 0, 0);
    check("rst_running", 16'h0008, 1, 0);
    idle(1);
    step(1, 0, 0, 0, 0);
    check("rst_midrun", 16'h0000, 0, 0);
    step(0, 1, 0, 0, 0);
    check("rst_start_ignored", 16'h0000, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
